vx_muldiv_sched: RTL and testbench

- Sequencer/arbiter that shares one serial iterative unit (divider or serial multiplier) among NUM_REQS requesters, such as per-issue-slice ALU M-extension paths.
- Arbitrates requests round-robin, latches operands and tag, and strobes the unit.
- Tracks the unit's busy handshake, captures the result and returns it with the requester index.
- Sits between the per-slice muldiv front ends and a single strobe/busy-style serial unit.

---
 rtl/vx_muldiv_sched_pkg.sv | 16 +
 rtl/vx_muldiv_rr_pick.sv | 33 +++
 rtl/vx_muldiv_sched.sv | 153 +++++++++++++++
 tb/tb_vx_muldiv_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_muldiv_sched_pkg.sv
// Shared types for the muldiv scheduler: FSM state encoding and index-width helper.
// Pure declarations, no logic.
package vx_muldiv_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RSP   = 2'd3
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_muldiv_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping N-1 -> 0.
// Purely combinational; no backpressure of its own.
module vx_muldiv_rr_pick
    import vx_muldiv_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = '0;
        for (int i = 0; i < N; i++) begin
            pos = IW'((int'(ptr_i) + i) % N);
            if (!any_o && valid_i[pos]) begin
                any_o        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
    end

endmodule

// File: rtl/vx_muldiv_sched.sv
// Shares one strobe/busy serial unit among NUM_REQS requesters, round-robin; optional VX_MULDIV_SCHED_PERF_EN adds perf counters.
// Latency: fire->strobe 1 cycle, busy low->rsp_valid 1 cycle; one op in flight.
// Backpressure: requests accepted only in IDLE; rsp held stable until rsp_ready.
module vx_muldiv_sched
    import vx_muldiv_sched_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 128,
    parameter int RESW     = 64,
    parameter int TAGW     = 32,
    localparam int IDXW    = idx_width(NUM_REQS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQS-1:0]      req_valid,
    output logic [NUM_REQS-1:0]      req_ready,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    input  logic [NUM_REQS*TAGW-1:0] req_tag,
    output logic                     unit_strobe,
    input  logic                     unit_busy,
    output logic [DATAW-1:0]         unit_data,
    input  logic [RESW-1:0]          unit_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RESW-1:0]          rsp_result,
    output logic [TAGW-1:0]          rsp_tag,
    output logic [IDXW-1:0]          rsp_idx
`ifdef VX_MULDIV_SCHED_PERF_EN
    ,
    output logic [63:0]              perf_busy_cycles,
    output logic [63:0]              perf_stall_cycles
`endif
);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATAW-1:0]  unit_data_q, unit_data_d;
    logic [RESW-1:0]   res_q, res_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic [IDXW-1:0]   idx_q, idx_d;

    logic [NUM_REQS-1:0] grant;
    logic [IDXW-1:0]     gidx;
    logic                any_vld;

    logic [DATAW-1:0] data_a [NUM_REQS];
    logic [TAGW-1:0]  tag_a  [NUM_REQS];

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
        assign data_a[g] = req_data[g*DATAW +: DATAW];
        assign tag_a[g]  = req_tag[g*TAGW +: TAGW];
    end

    vx_muldiv_rr_pick #(
        .N  (NUM_REQS),
        .IW (IDXW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (any_vld)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        unit_data_d = unit_data_q;
        res_d       = res_q;
        tag_d       = tag_q;
        idx_d       = idx_q;
        req_ready   = '0;
        unit_strobe = 1'b0;
        rsp_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (any_vld) begin
                    unit_data_d = data_a[gidx];
                    tag_d       = tag_a[gidx];
                    idx_d       = gidx;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                unit_strobe = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                // A zero-iteration unit never raises busy; its result is taken here directly.
                if (!unit_busy) begin
                    res_d   = unit_result;
                    state_d = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rr_ptr_d = (idx_q == IDXW'(NUM_REQS - 1)) ? '0 : idx_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            unit_data_q <= '0;
            res_q       <= '0;
            tag_q       <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            unit_data_q <= unit_data_d;
            res_q       <= res_d;
            tag_q       <= tag_d;
            idx_q       <= idx_d;
        end
    end

    assign unit_data  = unit_data_q;
    assign rsp_result = res_q;
    assign rsp_tag    = tag_q;
    assign rsp_idx    = idx_q;

`ifdef VX_MULDIV_SCHED_PERF_EN
    logic [63:0] perf_busy_q, perf_stall_q;
    logic        busy_inc, stall_inc;

    assign busy_inc  = (state_q == ISSUE) || (state_q == WAIT);
    assign stall_inc = (|req_valid) && !(|req_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_inc && (perf_busy_q != '1))
                perf_busy_q <= perf_busy_q + 64'd1;
            if (stall_inc && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 64'd1;
        end
    end

    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_vx_muldiv_sched.sv
// Randomized bench for vx_muldiv_sched with an event-timeline reference model and a behavioural serial unit.
module tb_vx_muldiv_sched;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int RW = 64;
    localparam int TW = 32;
    localparam int IW = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_data;
    logic [N*TW-1:0]   req_tag;
    logic              unit_strobe;
    logic              unit_busy;
    logic [DW-1:0]     unit_data;
    logic [RW-1:0]     unit_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RW-1:0]     rsp_result;
    logic [TW-1:0]     rsp_tag;
    logic [IW-1:0]     rsp_idx;
`ifdef VX_MULDIV_SCHED_PERF_EN
    logic [63:0]       perf_busy_cycles;
    logic [63:0]       perf_stall_cycles;
`endif

    logic [DW-1:0] tb_data [N];
    logic [TW-1:0] tb_tag  [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_data[g*DW +: DW] = tb_data[g];
        assign req_tag[g*TW +: TW]  = tb_tag[g];
    end

    vx_muldiv_sched #(
        .NUM_REQS (N),
        .DATAW    (DW),
        .RESW     (RW),
        .TAGW     (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_tag     (req_tag),
        .unit_strobe (unit_strobe),
        .unit_busy   (unit_busy),
        .unit_data   (unit_data),
        .unit_result (unit_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_tag     (rsp_tag),
        .rsp_idx     (rsp_idx)
`ifdef VX_MULDIV_SCHED_PERF_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Stimulus controls
    logic [N-1:0]  in_valid = '0;
    bit            in_rdy = 1'b1;
    bit            in_reset = 1'b0;
    int            next_iters = 0;
    bit            force_res_en = 1'b0;
    logic [RW-1:0] force_res = '0;
    bit            force_tag_en = 1'b0;
    logic [TW-1:0] force_tag = '0;

    // Reference model: one op in flight described by its accept cycle and iteration count
    int            cyc = 0;
    bit            outst = 1'b0;
    int            a_cyc = 0;
    int            iters = 0;
    int            ptr = 0;
    logic [DW-1:0] m_data = '0;
    logic [TW-1:0] m_tag = '0;
    int            m_idx = 0;
    logic [RW-1:0] m_res = '0;
    longint unsigned m_busy = 0;
    longint unsigned m_stall = 0;

    // Observed DUT events
    int            dut_fire_cyc = -1;
    int            dut_fire_idx = -1;
    int            dut_strobe_cyc = -1;
    int            rsp_rise_cyc = -1;
    bit            rv_prev = 1'b0;
    logic [RW-1:0] rise_res = '0;
    logic [TW-1:0] rise_tag = '0;
    logic [IW-1:0] rise_idx = '0;
    int            served_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic step();
        int g;
        logic [N-1:0] exp_ready;
        bit exp_rv;
        @(posedge clk);
        cyc++;
        #1;
        reset     = in_reset;
        req_valid = in_reset ? '0 : in_valid;
        for (int i = 0; i < N; i++) begin
            tb_data[i] = {$urandom, $urandom, $urandom, $urandom};
            tb_tag[i]  = force_tag_en ? force_tag : TW'($urandom);
        end
        rsp_ready   = in_rdy;
        unit_busy   = outst && (cyc >= a_cyc + 2) && (cyc <= a_cyc + 1 + iters);
        unit_result = (outst && cyc == a_cyc + 2 + iters) ? m_res : {$urandom, $urandom};
        #4;
        if (in_reset) begin
            outst   = 1'b0;
            ptr     = 0;
            m_busy  = 0;
            m_stall = 0;
            rv_prev = 1'b0;
        end else begin
            g = outst ? -1 : pick(req_valid, ptr);
            exp_ready = (g >= 0) ? N'(1 << g) : '0;
            exp_rv = outst && (cyc >= a_cyc + 3 + iters);
            check("req_ready", req_ready, exp_ready);
            check("unit_strobe", unit_strobe, outst && cyc == a_cyc + 1);
            check("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                check("rsp_result", rsp_result, m_res);
                check("rsp_tag", rsp_tag, m_tag);
                check("rsp_idx", rsp_idx, m_idx);
            end
            if (outst && cyc >= a_cyc + 1 && cyc <= a_cyc + 2 + iters)
                check("unit_data", unit_data, m_data);
`ifdef VX_MULDIV_SCHED_PERF_EN
            check("perf_busy", perf_busy_cycles, m_busy);
            check("perf_stall", perf_stall_cycles, m_stall);
            if (outst && cyc >= a_cyc + 1 && cyc <= a_cyc + 2 + iters) m_busy++;
            if ((|req_valid) && exp_ready == '0) m_stall++;
`endif
            // DUT-side event log
            if (|(req_valid & req_ready)) begin
                dut_fire_cyc = cyc;
                for (int i = 0; i < N; i++) if (req_ready[i]) dut_fire_idx = i;
            end
            if (unit_strobe === 1'b1) dut_strobe_cyc = cyc;
            if (rsp_valid === 1'b1 && !rv_prev) begin
                rsp_rise_cyc = cyc;
                rise_res = rsp_result;
                rise_tag = rsp_tag;
                rise_idx = rsp_idx;
            end
            rv_prev = (rsp_valid === 1'b1);
            // Model update
            if (exp_rv && in_rdy) begin
                served_q.push_back(m_idx);
                ptr   = (m_idx + 1) % N;
                outst = 1'b0;
            end
            if (g >= 0) begin
                outst  = 1'b1;
                a_cyc  = cyc;
                iters  = next_iters;
                m_data = tb_data[g];
                m_tag  = tb_tag[g];
                m_idx  = g;
                m_res  = force_res_en ? force_res : (m_data[63:0] ^ m_data[127:64]);
            end
        end
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        step();
        in_reset = 1'b0;
    endtask

    task automatic wait_fire(input int limit);
        int n = 0;
        while (!outst && n < limit) begin
            step();
            n++;
        end
        check("fire_timeout", outst, 1'b1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (outst && n < limit) begin
            step();
            n++;
        end
        check("idle_timeout", outst, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        rsp_ready   = 1'b0;
        unit_busy   = 1'b0;
        unit_result = '0;
        for (int i = 0; i < N; i++) begin
            tb_data[i] = '0;
            tb_tag[i]  = '0;
        end

        // Reset state
        do_reset();
        do_reset();
        in_valid = '0;
        step();
        check("rst_unit_data", unit_data, '0);
        check("rst_rsp_result", rsp_result, '0);
        check("rst_rsp_tag", rsp_tag, '0);
        check("rst_rsp_idx", rsp_idx, '0);
        check("rst_req_ready", req_ready, '0);

        // Single op: requester 2, tag 0x55, 32-cycle unit, result 0xDEAD
        force_tag_en = 1'b1; force_tag = 32'h55;
        force_res_en = 1'b1; force_res = 64'hDEAD;
        next_iters = 32;
        in_valid = 4'b0100;
        in_rdy = 1'b1;
        wait_fire(10);
        in_valid = '0;
        wait_idle(100);
        check("single_strobe_lat", dut_strobe_cyc - dut_fire_cyc, 1);
        check("single_rsp_lat", rsp_rise_cyc - dut_fire_cyc, 35);
        check("single_idx", rise_idx, 2);
        check("single_tag", rise_tag, 32'h55);
        check("single_res", rise_res, 64'hDEAD);
        force_tag_en = 1'b0;
        force_res_en = 1'b0;

        // Round-robin from a fresh pointer with every requester valid
        do_reset();
        served_q.delete();
        in_valid = 4'hF;
        for (int n = 0; n < 300 && served_q.size() < 5; n++) begin
            next_iters = $urandom_range(0, 3);
            step();
        end
        check("rr_count", served_q.size() >= 5, 1'b1);
        if (served_q.size() >= 5) begin
            check("rr_0", served_q[0], 0);
            check("rr_1", served_q[1], 1);
            check("rr_2", served_q[2], 2);
            check("rr_3", served_q[3], 3);
            check("rr_4", served_q[4], 0);
        end
        in_valid = '0;
        wait_idle(100);

        // Backpressure: hold rsp_ready low for 10 cycles in RSP while others wait
        in_valid = 4'b0010;
        next_iters = 4;
        in_rdy = 1'b0;
        wait_fire(10);
        in_valid = 4'hF;
        repeat (4 + 3 + 10) step();
        check("bp_held", rsp_valid, 1'b1);
        in_rdy = 1'b1;
        in_valid = '0;
        wait_idle(20);

        // Reset during the fifth WAIT cycle, then pointer must restart at 0
        in_valid = 4'b0001;
        next_iters = 20;
        wait_fire(10);
        in_valid = '0;
        repeat (5) step();
        do_reset();
        check("rst_wait_rsp_valid", rsp_valid, 1'b0);
        check("rst_wait_strobe", unit_strobe, 1'b0);
        in_valid = 4'b1010;
        next_iters = 2;
        wait_fire(10);
        check("rst_wait_grant", dut_fire_idx, 1);
        in_valid = '0;
        wait_idle(30);

        // Zero-iteration unit
        in_valid = 4'b0100;
        next_iters = 0;
        wait_fire(10);
        in_valid = '0;
        wait_idle(20);
        check("zero_iter_lat", rsp_rise_cyc - dut_fire_cyc, 3);

`ifdef VX_MULDIV_SCHED_PERF_EN
        // Two requesters for 40 cycles with a 32-cycle unit
        do_reset();
        in_valid = 4'b0011;
        next_iters = 32;
        in_rdy = 1'b1;
        repeat (40) step();
        check("perf_busy_lit", perf_busy_cycles, 64'd36);
        check("perf_stall_lit", perf_stall_cycles, 64'd37);
        in_valid = '0;
        wait_idle(100);
`endif

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            in_valid   = N'($urandom);
            in_rdy     = ($urandom_range(0, 3) != 0);
            next_iters = $urandom_range(0, 6);
            step();
        end
        in_valid = '0;
        in_rdy = 1'b1;
        wait_idle(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
